// File: rtl/uart_rx_perif.sv
// uart_rx_perif: 8N1 UART receiver with a small receive FIFO, exposed to a 6502 bus as two registers.
// Latency: a byte becomes readable in the cycle after its stop-bit sample; the rx_pin synchronizer adds 2 cycles.
// Backpressure: none on the serial side; a byte that arrives while the FIFO is full is dropped and overrun is set.
//
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset
//   AB, WE, CS, DI   CPU register select, write strobe, chip select and write data
//   DO               CPU read data, driven only while CS=1 and WE=0, otherwise 8'bz
//   rx_pin           asynchronous serial input, idle high, LSB first
//   irq              high while the FIFO holds data and irq_en is set
module uart_rx_perif #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] AB,
  input  logic       WE,
  input  logic       CS,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rx_pin,
  output logic       irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer; reset to the idle level so a reset never fakes a start
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;

  // The stop-sample decode is combinational so the FIFO write lands in the
  // same cycle as the sample and the byte is visible one cycle later.
  logic stop_sample;
  logic push;
  logic frame_evt;

  assign stop_sample = (state_q == S_STOP) && (cnt_q == BIT_LAST);
  assign push        = stop_sample & rxs;
  assign frame_evt   = stop_sample & ~rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit; a high level here was a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= rxs ? S_IDLE : S_BREAK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not taken as a new start bit.
          if (rxs) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CPU access decode
  // ---------------------------------------------------------------------------
  logic rd_sel, rd_sel_q;
  logic reg_wr;

  assign rd_sel = CS & ~WE & (AB == 2'd0);
  assign reg_wr = CS & WE & (AB == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q <= 1'b0;
    end else begin
      rd_sel_q <= rd_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_empty, fifo_full;
  logic             pop, wr_en, ovr_evt;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // Pop on the trailing edge of the head read so DO holds still for the access.
  assign pop     = rd_sel_q & ~rd_sel & ~fifo_empty;
  // A simultaneous pop frees a slot, so a push at full still succeeds.
  assign wr_en   = push & (~fifo_full | pop);
  assign ovr_evt = push & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  // ---------------------------------------------------------------------------
  // Status flags; a new error event wins over a same-cycle clear
  // ---------------------------------------------------------------------------
  logic overrun_q, frame_err_q, irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      if (ovr_evt)                overrun_q <= 1'b1;
      else if (reg_wr && DI[3])   overrun_q <= 1'b0;

      if (frame_evt)              frame_err_q <= 1'b1;
      else if (reg_wr && DI[2])   frame_err_q <= 1'b0;

      if (reg_wr)                 irq_en_q <= DI[7];
    end
  end

  logic unused_di;
  assign unused_di = ^{DI[6:4], DI[1:0]};

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (AB)
      2'd0:    rd_data = fifo_empty ? 8'h00 : mem[rd_ptr_q];
      2'd1:    rd_data = {irq_en_q, 3'b000, overrun_q, frame_err_q, fifo_full, ~fifo_empty};
      default: rd_data = 8'h00;
    endcase
  end

  assign DO  = (CS && !WE) ? rd_data : 8'bz;
  assign irq = irq_en_q & ~fifo_empty;

endmodule
